uc_multiciclo: RTL and testbench

Multicycle control FSM for the MIPS datapath. It sits directly upstream of the datapath top and drives the PC register, IR, register bank, muxes, memory and ULA selector.
- Per-instruction sequencing: FETCH, DECODE, EXEC, MEM, WB.
- Consumes opcode/funct from the IR and zero/overflow flags from the ULA.
- Supports lw, sw, R-type (add, sub, and, xor), addi, beq, bne, j.

---
 rtl/uc_pkg.sv | 101 ++++++++++
 rtl/uc_out_decode.sv | 98 +++++++++
 rtl/uc_multiciclo.sv | 161 ++++++++++++++++
 tb/tb_uc_multiciclo.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// The state list always includes EXC; it is only reachable when the
// UC_EXCEPTION_EN macro is defined.
package uc_pkg;

  // Controller states, in instruction sequencing order
  typedef enum logic [3:0] {
    RST_ST    = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_RD    = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WR    = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    ADDI_EXEC = 4'd9,
    ADDI_WB   = 4'd10,
    BRANCH    = 4'd11,
    JUMP      = 4'd12,
    EXC       = 4'd13
  } uc_state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_XOR = 6'h26;

  // ULA operation selector codes
  localparam logic [2:0] ULA_LOADA = 3'b000;
  localparam logic [2:0] ULA_ADD   = 3'b001;
  localparam logic [2:0] ULA_SUB   = 3'b010;
  localparam logic [2:0] ULA_AND   = 3'b011;
  localparam logic [2:0] ULA_XOR   = 3'b110;

  // ALU operand B mux encodings
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source mux encodings
  localparam logic [1:0] PCSRC_ULA    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  // Full control vector produced for one state
  typedef struct packed {
    logic       empty_pc;
    logic       pc_write;       // unconditional PC load request
    logic       pc_write_cond;  // branch PC load, qualified by Zero
    logic       ir_write;       // qualified by the wait counter in FETCH
    logic       iord;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] seletor;
    logic       epc_write;
  } ctrl_t;

  // True for the R-type functions this datapath implements
  function automatic logic funct_valid(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) ||
           (funct == FN_AND) || (funct == FN_XOR);
  endfunction

  // ULA selector for an R-type function; LOADA for anything unknown
  function automatic logic [2:0] funct_to_ula(input logic [5:0] funct);
    logic [2:0] sel;
    sel = ULA_LOADA;
    case (funct)
      FN_ADD:  sel = ULA_ADD;
      FN_SUB:  sel = ULA_SUB;
      FN_AND:  sel = ULA_AND;
      FN_XOR:  sel = ULA_XOR;
      default: sel = ULA_LOADA;
    endcase
    return sel;
  endfunction

  // Only arithmetic R-type functions can raise a meaningful overflow
  function automatic logic funct_arith(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB);
  endfunction

endpackage

// File: rtl/uc_out_decode.sv
// Combinational state -> control vector decoder for uc_multiciclo.
// Funct is consulted only to pick the ULA operation in R_EXEC.
// The EXC row is populated only when UC_EXCEPTION_EN is defined.
module uc_out_decode
  import uc_pkg::*;
(
  input  uc_state_t   state,
  input  logic [5:0]  funct,
  output ctrl_t       ctrl
);

  // Moore decode: every field defaults to 0 and each state sets its own
  always_comb begin
    ctrl = '0;
    case (state)
      RST_ST: begin
        ctrl.empty_pc = 1'b1;
      end
      FETCH: begin
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.seletor   = ULA_ADD;
        ctrl.pc_source = PCSRC_ULA;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
      end
      DECODE: begin
        // Precompute the branch target into ALUOut
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.seletor   = ULA_ADD;
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.seletor   = ULA_ADD;
      end
      MEM_RD: begin
        ctrl.iord = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      MEM_WR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.seletor   = funct_to_ula(funct);
      end
      R_WB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.seletor   = ULA_ADD;
      end
      ADDI_WB: begin
        ctrl.reg_dst   = 1'b0;
        ctrl.reg_write = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.seletor       = ULA_SUB;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
      end
      JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
`ifdef UC_EXCEPTION_EN
      EXC: begin
        // PC was already advanced in FETCH; PC-4 goes to EPC
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.seletor   = ULA_SUB;
        ctrl.epc_write = 1'b1;
        ctrl.pc_source = PCSRC_EXC;
        ctrl.pc_write  = 1'b1;
      end
`endif
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle MIPS control FSM (lw, sw, add/sub/and/xor, addi, beq, bne, j).
// Optional feature macro: UC_EXCEPTION_EN enables the EXC state
// (overflow on add/sub/addi and invalid Op/Funct trap to EXC_VECTOR).
// Without it, overflow is ignored and invalid instructions act as NOPs.
// dbg_state mirrors the state register for observation.
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int          MEM_WAIT   = 1,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_00FF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       Overflow,
  output logic       Empty_PC,
  output logic       Load_PC,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] Seletor_ULA,
  output logic       EPCWrite,
  output uc_state_t  dbg_state
);

  localparam logic [1:0] WAIT_INIT = 2'(MEM_WAIT);

  uc_state_t  state;
  logic [1:0] wait_cnt;
  logic       wait_done;
  logic       is_beq;
  ctrl_t      ctrl;

  // The vector itself is consumed by the datapath mux, not here
  logic [31:0] unused_exc_vector;
  assign unused_exc_vector = EXC_VECTOR;

`ifndef UC_EXCEPTION_EN
  logic unused_overflow;
  assign unused_overflow = Overflow;
`endif

  assign wait_done = (wait_cnt == 2'd0);
  assign is_beq    = (Op == OP_BEQ);

  // State register and memory wait counter; counter reloads on every
  // entry into FETCH or MEM_RD and those states hold until it reaches 0
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= RST_ST;
      wait_cnt <= WAIT_INIT;
    end else begin
      case (state)
        RST_ST: begin
          state    <= FETCH;
          wait_cnt <= WAIT_INIT;
        end
        FETCH: begin
          if (!wait_done) wait_cnt <= wait_cnt - 2'd1;
          else            state    <= DECODE;
        end
        DECODE: begin
          case (Op)
            OP_RTYPE:      state <= R_EXEC;
            OP_LW, OP_SW:  state <= MEM_ADDR;
            OP_ADDI:       state <= ADDI_EXEC;
            OP_BEQ,OP_BNE: state <= BRANCH;
            OP_J:          state <= JUMP;
            default: begin
`ifdef UC_EXCEPTION_EN
              state    <= EXC;
`else
              state    <= FETCH;
              wait_cnt <= WAIT_INIT;
`endif
            end
          endcase
        end
        MEM_ADDR: begin
          if (Op == OP_LW) begin
            state    <= MEM_RD;
            wait_cnt <= WAIT_INIT;
          end else begin
            state    <= MEM_WR;
          end
        end
        MEM_RD: begin
          if (!wait_done) wait_cnt <= wait_cnt - 2'd1;
          else            state    <= MEM_WB;
        end
        R_EXEC: begin
          if (!funct_valid(Funct)) begin
`ifdef UC_EXCEPTION_EN
            state    <= EXC;
`else
            state    <= FETCH;
            wait_cnt <= WAIT_INIT;
`endif
          end
`ifdef UC_EXCEPTION_EN
          else if (Overflow && funct_arith(Funct)) begin
            state <= EXC;
          end
`endif
          else begin
            state <= R_WB;
          end
        end
        ADDI_EXEC: begin
`ifdef UC_EXCEPTION_EN
          if (Overflow) state <= EXC;
          else          state <= ADDI_WB;
`else
          state <= ADDI_WB;
`endif
        end
        MEM_WB, MEM_WR, R_WB, ADDI_WB, BRANCH, JUMP, EXC: begin
          state    <= FETCH;
          wait_cnt <= WAIT_INIT;
        end
        default: begin
          state    <= RST_ST;
          wait_cnt <= WAIT_INIT;
        end
      endcase
    end
  end

  uc_out_decode u_out_decode (
    .state (state),
    .funct (Funct),
    .ctrl  (ctrl)
  );

  // FETCH only commits IR and PC on its final wait cycle; the branch
  // load is the one Mealy term (taken on Zero for beq, on !Zero for bne)
  assign IRWrite     = ctrl.ir_write & wait_done;
  assign Load_PC     = (ctrl.pc_write & wait_done) |
                       (ctrl.pc_write_cond & ~(Zero ^ is_beq));
  assign Empty_PC    = ctrl.empty_pc;
  assign IorD        = ctrl.iord;
  assign MemWrite    = ctrl.mem_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign Seletor_ULA = ctrl.seletor;
  assign EPCWrite    = ctrl.epc_write;
  assign dbg_state   = state;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Self-checking bench for uc_multiciclo with MEM_WAIT=1.
// Expected per-cycle control vectors are pushed to exp_q when an
// instruction is driven and popped as each cycle is sampled on negedge.
module tb_uc_multiciclo;
  import uc_pkg::*;

`ifdef UC_EXCEPTION_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero, overflow;
  logic       empty_pc, load_pc, ir_write, iord, mem_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, epc_write;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] seletor;
  uc_state_t  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  uc_multiciclo #(.MEM_WAIT(1), .EXC_VECTOR(32'h0000_00FF)) dut (
    .Clk(clk), .Reset(rst_n), .Op(op), .Funct(funct), .Zero(zero),
    .Overflow(overflow), .Empty_PC(empty_pc), .Load_PC(load_pc),
    .IRWrite(ir_write), .IorD(iord), .MemWrite(mem_write),
    .MemtoReg(mem_to_reg), .RegDst(reg_dst), .RegWrite(reg_write),
    .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .PCSource(pc_source),
    .Seletor_ULA(seletor), .EPCWrite(epc_write), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard helpers
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] pack(input uc_state_t st, input logic empty,
      input logic load, input logic irw, input logic io, input logic mw,
      input logic m2r, input logic rd, input logic rw, input logic sa,
      input logic [1:0] sb, input logic [1:0] pcs, input logic [2:0] sel,
      input logic epc);
    return {11'd0, st, empty, load, irw, io, mw, m2r, rd, rw, sa, sb, pcs, sel, epc};
  endfunction

  function automatic logic [31:0] observe();
    return pack(dbg_state, empty_pc, load_pc, ir_write, iord, mem_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                pc_source, seletor, epc_write);
  endfunction

  // st, load, irw, iord, memw, m2r, rdst, rw, srca, srcb, pcs, sel, epc
  task automatic push(input uc_state_t st, input logic load, input logic irw,
      input logic io, input logic mw, input logic m2r, input logic rd,
      input logic rw, input logic sa, input logic [1:0] sb,
      input logic [1:0] pcs, input logic [2:0] sel, input logic epc);
    exp_q.push_back(pack(st, 1'b0, load, irw, io, mw, m2r, rd, rw, sa, sb, pcs, sel, epc));
  endtask

  task automatic push_exc();
    push(EXC, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b11, 3'b010, 1);
  endtask

  // Reference sequence of control vectors for one instruction
  task automatic push_instr(input logic [5:0] o, input logic [5:0] f,
                            input logic z, input logic ov);
    logic       fvalid;
    logic [2:0] rsel;
    logic       taken;
    push(FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b001, 0);
    push(FETCH, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b001, 0);
    push(DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b001, 0);
    case (o)
      6'h00: begin
        fvalid = 1'b1;
        case (f)
          6'h20: rsel = 3'b001;
          6'h22: rsel = 3'b010;
          6'h24: rsel = 3'b011;
          6'h26: rsel = 3'b110;
          default: begin rsel = 3'b000; fvalid = 1'b0; end
        endcase
        push(R_EXEC, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, rsel, 0);
        if (!fvalid) begin
          if (EXC_EN) push_exc();
        end else if (EXC_EN && ov && (f == 6'h20 || f == 6'h22)) begin
          push_exc();
        end else begin
          push(R_WB, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b000, 0);
        end
      end
      6'h23: begin
        push(MEM_ADDR, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b001, 0);
        push(MEM_RD, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
        push(MEM_RD, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
        push(MEM_WB, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0);
      end
      6'h2B: begin
        push(MEM_ADDR, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b001, 0);
        push(MEM_WR, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
      end
      6'h08: begin
        push(ADDI_EXEC, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b001, 0);
        if (EXC_EN && ov) push_exc();
        else push(ADDI_WB, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0);
      end
      6'h04, 6'h05: begin
        taken = (o == 6'h04) ? z : ~z;
        push(BRANCH, taken, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b010, 0);
      end
      6'h02: begin
        push(JUMP, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 0);
      end
      default: begin
        if (EXC_EN) push_exc();
      end
    endcase
  endtask

  task automatic pop_compare(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_underflow"}, observe(), 32'hDEAD_BEEF);
    end else begin
      check(tag, observe(), exp_q.pop_front());
    end
  endtask

  task automatic run_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      pop_compare(tag);
      @(negedge clk);
    end
  endtask

  // Driver: called at the first FETCH cycle, leaves DUT at the next FETCH
  task automatic run_instr(input string tag, input logic [5:0] o,
                           input logic [5:0] f, input logic z, input logic ov);
    int n;
    op = o; funct = f; zero = z; overflow = ov;
    #1;
    push_instr(o, f, z, ov);
    n = exp_q.size();
    run_cycles(tag, n);
  endtask

  logic [31:0] rst_vec;
  logic [5:0]  op_tab [0:10];
  logic [5:0]  fn_tab [0:10];

  initial begin
    rst_vec = pack(RST_ST, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0);
    op_tab = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h02, 6'h3F};
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h26, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    rst_n = 1'b0; op = 6'h00; funct = 6'h00; zero = 1'b0; overflow = 1'b0;

    // Reset held 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", observe(), rst_vec);
    end
    rst_n = 1'b1;
    #1 check("reset_release", observe(), rst_vec);
    @(negedge clk);

    // Directed instructions
    run_instr("r_sub",     6'h00, 6'h22, 0, 0);
    run_instr("r_add",     6'h00, 6'h20, 1, 0);
    run_instr("r_and",     6'h00, 6'h24, 0, 0);
    run_instr("r_xor",     6'h00, 6'h26, 0, 0);
    run_instr("r_and_ovf", 6'h00, 6'h24, 0, 1);
    run_instr("lw",        6'h23, 6'h00, 0, 0);
    run_instr("sw",        6'h2B, 6'h00, 0, 0);
    run_instr("lw_ovf",    6'h23, 6'h00, 0, 1);
    run_instr("beq_z1",    6'h04, 6'h00, 1, 0);
    run_instr("beq_z0",    6'h04, 6'h00, 0, 0);
    run_instr("bne_z0",    6'h05, 6'h00, 0, 0);
    run_instr("bne_z1",    6'h05, 6'h00, 1, 0);
    run_instr("jump",      6'h02, 6'h00, 0, 0);
    run_instr("addi",      6'h08, 6'h00, 0, 0);
    run_instr("addi_ovf",  6'h08, 6'h00, 0, 1);
    run_instr("add_ovf",   6'h00, 6'h20, 0, 1);
    run_instr("op_3f",     6'h3F, 6'h00, 0, 0);
    run_instr("fn_3f",     6'h00, 6'h3F, 0, 0);

    // Random mix
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 10);
      run_instr("rand", op_tab[k], fn_tab[k],
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset asserted mid-MEM_WR drops MemWrite without a clock edge
    op = 6'h2B; funct = 6'h00; zero = 1'b0; overflow = 1'b0;
    #1;
    push_instr(6'h2B, 6'h00, 1'b0, 1'b0);
    run_cycles("sw_pre", 4);
    pop_compare("sw_memwr");
    #2 rst_n = 1'b0;
    #1 check("async_memwrite", {31'd0, mem_write}, 32'd0);
    check("async_state", observe(), rst_vec);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_mid_hold", observe(), rst_vec);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_instr("post_reset_sw", 6'h2B, 6'h00, 0, 0);
    run_instr("post_reset_r",  6'h00, 6'h22, 0, 0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
